// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, frame constants and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int uart_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/baud_gen.sv
// baud_gen: reloadable bit-period down-counter; tick marks the last clock of a bit
module baud_gen #(
  parameter int DIVISOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = $clog2(DIVISOR);
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_load || o_tick) r_cnt <= W'(DIVISOR - 1);
    else if (i_en) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one-byte 8N1 serial transmitter, LSB first; define UART_TX_PARITY_EN for 8E1
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115_200,
  parameter int DIVISOR = uart_divisor(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_start_n,
  output logic       tx_ready,
  output logic       tx
);
  if (DIVISOR < 2) begin : g_div_chk
    $error("uart_tx: DIVISOR must be >= 2");
  end
  uart_state_t r_state;
  logic        r_start_n_q, r_tx, r_ready;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit_idx;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif
  logic        w_req, w_load, w_tick;
  // only a falling edge requests, so a decoder holding start_n low cannot retrigger
  assign w_req    = r_start_n_q && !tx_start_n;
  assign w_load   = (r_state == IDLE) && w_req;
  assign tx       = r_tx;
  assign tx_ready = r_ready;
  baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_en  (r_state != IDLE),
    .o_tick(w_tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      r_start_n_q <= 1'b1;
      r_tx        <= 1'b1;
      r_ready     <= 1'b1;
      r_shreg     <= '0;
      r_bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_start_n_q <= tx_start_n;
      case (r_state)
        IDLE: if (w_req) begin
          r_state <= START;
          r_shreg <= tx_byte;
          r_tx    <= 1'b0;
          r_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^tx_byte;
`endif
        end
        START: if (w_tick) begin
          r_state   <= DATA;
          r_bit_idx <= '0;
          r_tx      <= r_shreg[0];
        end
        DATA: if (w_tick) begin
          r_shreg   <= r_shreg >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            r_state <= PARITY;
            r_tx    <= r_par;
`else
            r_state <= STOP;
            r_tx    <= 1'b1;
`endif
          end else r_tx <= r_shreg[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_tick) begin
          r_state <= STOP;
          r_tx    <= 1'b1;
        end
`endif
        STOP: if (w_tick) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-timing model plus literal frame checks for uart_tx (DIVISOR=4)
module tb_uart_tx;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
  localparam logic [10:0] EXP55 = 11'h4AA;
  localparam logic [10:0] EXPA3 = 11'h546;
`else
  localparam int FRAME = 10;
  localparam logic [10:0] EXP55 = 11'h2AA;
  localparam logic [10:0] EXPA3 = 11'h346;
`endif
  localparam int LEN = FRAME * D;
  logic clk = 1'b0, rst = 1'b0, tx_start_n = 1'b1, tx_ready, tx;
  logic [7:0] tx_byte = 8'h00;
  int total = 0, bad = 0;
  uart_tx #(.CLK_HZ(1_000_000), .BAUD(250_000)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_start_n(tx_start_n),
    .tx_ready(tx_ready), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // model: a frame is a list of bit values, each held D clocks from the accepting edge
  bit m_act = 0;
  logic m_prev = 1'b1;
  int m_n = 0;
  logic [10:0] m_bits = '0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_act = 0; m_prev = 1'b1; m_n = 0;
    end else begin
      if (m_prev && !tx_start_n && !m_act) begin
        m_act = 1; m_n = 0;
`ifdef UART_TX_PARITY_EN
        m_bits = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
        m_bits = {2'b11, tx_byte, 1'b0};
`endif
      end else if (m_act) begin
        m_n++;
        if (m_n == LEN) m_act = 0;
      end
      m_prev = tx_start_n;
    end
  always @(negedge clk)
    if (rst) begin
      check("model_tx", 32'(tx), 32'(m_act ? m_bits[m_n / D] : 1'b1));
      check("model_ready", 32'(tx_ready), 32'(!m_act));
    end
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [7:0] b, input bit hold, input int inj,
                      output logic [10:0] got, output int rise, output bit extra);
    tx_byte = b; tx_start_n = 1'b0;
    step;
    got = '0; rise = -1; extra = 0;
    for (int c = 0; c < LEN + 20; c++) begin
      if (c % D == 1 && c / D < FRAME) got[c / D] = tx;
      if (rise < 0 && tx_ready) rise = c;
      if (rise >= 0 && !tx) extra = 1;
      if (!hold) begin
        tx_start_n = (c != inj - 1);
        if (c == inj - 1) tx_byte = 8'hFF;
      end
      step;
    end
    tx_start_n = 1'b1;
    step;
  endtask
  logic [10:0] got;
  int rise;
  bit extra;
  initial begin
    repeat (3) step;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_ready", 32'(tx_ready), 32'h1);
    rst = 1'b1;
    repeat (2) step;
    check("idle_tx", 32'(tx), 32'h1);
    send(8'h55, 0, -1, got, rise, extra);
    check("f55_bits", 32'(got), 32'(EXP55));
    check("f55_rise", 32'(rise), 32'(LEN));
    check("f55_extra", 32'(extra), 32'h0);
    send(8'h55, 1, -1, got, rise, extra);
    check("hold_bits", 32'(got), 32'(EXP55));
    check("hold_rise", 32'(rise), 32'(LEN));
    check("hold_noretrig", 32'(extra), 32'h0);
    send(8'h55, 0, 12, got, rise, extra);
    check("busy_bits", 32'(got), 32'(EXP55));
    check("busy_rise", 32'(rise), 32'(LEN));
    check("busy_noqueue", 32'(extra), 32'h0);
    tx_byte = 8'h55; tx_start_n = 1'b0;
    step;
    tx_start_n = 1'b1;
    repeat (17) step;
    check("mid_ready", 32'(tx_ready), 32'h0);
    step;
    rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'h1);
    check("async_rst_ready", 32'(tx_ready), 32'h1);
    #2 rst = 1'b1;
    repeat (3) step;
    check("post_rst_tx", 32'(tx), 32'h1);
    send(8'hA3, 0, -1, got, rise, extra);
    check("fa3_bits", 32'(got), 32'(EXPA3));
    check("fa3_rise", 32'(rise), 32'(LEN));
`ifdef UART_TX_PARITY_EN
    send(8'h07, 0, -1, got, rise, extra);
    check("f07_bits", 32'(got), 32'h60E);
    check("f07_rise", 32'(rise), 32'd44);
`endif
    tx_byte = 8'h0F; tx_start_n = 1'b0;
    step;
    tx_start_n = 1'b1;
    repeat (LEN - 1) step;
    check("b2b_first_busy", 32'(tx_ready), 32'h0);
    step;
    check("b2b_ready", 32'(tx_ready), 32'h1);
    check("b2b_stop", 32'(tx), 32'h1);
    tx_byte = 8'hF0; tx_start_n = 1'b0;
    step;
    check("b2b_start", 32'(tx), 32'h0);
    check("b2b_busy", 32'(tx_ready), 32'h0);
    tx_start_n = 1'b1;
    repeat (LEN - 1) step;
    check("b2b_second_busy", 32'(tx_ready), 32'h0);
    step;
    check("b2b_second_rise", 32'(tx_ready), 32'h1);
    repeat (5) step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
